// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the programmable serial sequence detector.
package seq_det_pkg;

    localparam int unsigned SEQ_MAX_LEN = 8;
    localparam int unsigned SEQ_LEN_W   = 4;
    localparam int unsigned SEQ_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_match_core.sv
// Serial history shift register with a length-masked pattern compare.
// The match output is combinational on the post-shift history and bit count.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = SEQ_MAX_LEN,
    parameter int unsigned LEN_W   = SEQ_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift,
    input  logic               din,
    input  logic               flush,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               match
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_d;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   seen_q;
    logic [LEN_W-1:0]   seen_d;

    always_comb begin
        hist_d = {hist_q[MAX_LEN-2:0], din};
        seen_d = (seen_q >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : seen_q + LEN_W'(1);
        mask   = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        match = shift && (((hist_d ^ pattern) & mask) == '0) && (seen_d >= len);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist_q <= '0;
            seen_q <= '0;
        end else if (shift) begin
            hist_q <= hist_d;
            // Non-overlap: forget the matched bits so they cannot seed the next hit.
            seen_q <= (match && flush) ? '0 : seen_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Controller around seq_match_core: config port, IDLE/RUN/DONE FSM,
// saturating hit counter and registered detect pulse.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = SEQ_MAX_LEN,
    parameter int unsigned LEN_W   = SEQ_LEN_W,
    parameter int unsigned CNT_W   = SEQ_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    input  logic               in,
    output logic               detected,
    output logic [CNT_W-1:0]   hit_count,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    state_t             state_q;
    state_t             state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic               loaded_q;
    logic               err_q;
    logic [CNT_W-1:0]   hit_q;
    logic [CNT_W-1:0]   hit_inc;
    logic               det_q;
    logic               cfg_hs;
    logic               shift;
    logic               enter_run;
    logic               match;

    always_comb begin
        cfg_ready = (state_q == IDLE) && !rst;
        cfg_hs    = cfg_valid && cfg_ready;
        // stop wins over a completing bit, so the bit is not even shifted in.
        shift     = (state_q == RUN) && in_valid && !stop;
        hit_inc   = (hit_q == '1) ? hit_q : hit_q + CNT_W'(1);
        state_d   = state_q;
        unique case (state_q)
            IDLE: if (start && !cfg_hs && loaded_q && !err_q) state_d = RUN;
            RUN: begin
                if (stop) state_d = IDLE;
                else if (match && (tgt_q != '0) && (hit_inc == tgt_q)) state_d = DONE;
            end
            DONE: if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
        enter_run = (state_d == RUN) && (state_q != RUN);
    end

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clear   (enter_run),
        .shift   (shift),
        .din     (in),
        .flush   (!ovl_q),
        .pattern (pat_q),
        .len     (len_q),
        .match   (match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            ovl_q    <= 1'b0;
            tgt_q    <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            hit_q    <= '0;
            det_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            det_q   <= match;
            if (enter_run)  hit_q <= '0;
            else if (match) hit_q <= hit_inc;
            if (cfg_hs) begin
                pat_q    <= cfg_pattern;
                len_q    <= cfg_len;
                ovl_q    <= cfg_overlap;
                tgt_q    <= cfg_target;
                err_q    <= (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
                loaded_q <= 1'b1;
            end
        end
    end

    assign detected  = det_q;
    assign hit_count = hit_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign cfg_err   = err_q;

endmodule
